// File: rtl/alu_add_pkg.sv
// Shared ALU package: default datapath width.
// Imported by the adder cells and the alu_add top.
package alu_add_pkg;

  localparam int BUS_WIDTH_DEF = 16;

endpackage

// File: rtl/alu_add_cells.sv
// Adder cells for the ripple-carry chain.
// Ports are output-first: (sum, carry, x, y[, z]).
module half_adder_cell (
  output logic sum,
  output logic carry,
  input  logic x,
  input  logic y
);

  assign sum   = x ^ y;
  assign carry = x & y;

endmodule

module full_adder_cell (
  output logic sum,
  output logic carry,
  input  logic x,
  input  logic y,
  input  logic z
);

  logic s0;
  logic c0;
  logic c1;

  half_adder_cell u_ha0 (
    .sum   (s0),
    .carry (c0),
    .x     (x),
    .y     (y)
  );

  half_adder_cell u_ha1 (
    .sum   (sum),
    .carry (c1),
    .x     (s0),
    .y     (z)
  );

  // The two half-adder carries can never both be high,
  // so OR gives the majority of x, y, z.
  assign carry = c0 | c1;

endmodule

// File: rtl/alu_add.sv
// Registered unsigned ripple-carry adder (BUS_WIDTH >= 2).
// Ports: clk, rst (sync, high), a, b -> sum, carry (1-cycle latency).
module alu_add
  import alu_add_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  output logic                 carry,
  output logic [BUS_WIDTH-1:0] sum
);

  logic [BUS_WIDTH-1:0] s;
  // c[i] is the carry into bit i; c[BUS_WIDTH] is carry-out.
  logic [BUS_WIDTH:1]   c;

  half_adder_cell u_ha (
    .sum   (s[0]),
    .carry (c[1]),
    .x     (a[0]),
    .y     (b[0])
  );

  for (genvar i = 1; i < BUS_WIDTH; i++) begin : g_fa
    full_adder_cell u_fa (
      .sum   (s[i]),
      .carry (c[i+1]),
      .x     (a[i]),
      .y     (b[i]),
      .z     (c[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      sum   <= s;
      carry <= c[BUS_WIDTH];
    end
  end

endmodule

// File: tb/tb_alu_add.sv
// Self-checking bench for alu_add and its adder cells.
// Directed vector table, hand sequences, cell tables, random pairs.
module tb_alu_add;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry;
  logic [W-1:0] sum;

  logic hx, hy, hs, hc;
  logic fx, fy, fz, fs, fc;

  int n_cmp;
  int n_bad;

  alu_add #(.BUS_WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .carry (carry),
    .sum   (sum)
  );

  half_adder_cell u_ha (
    .sum   (hs),
    .carry (hc),
    .x     (hx),
    .y     (hy)
  );

  full_adder_cell u_fa (
    .sum   (fs),
    .carry (fc),
    .x     (fx),
    .y     (fy),
    .z     (fz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         carry;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  // Apply inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic [W-1:0] va,
                      input logic [W-1:0] vb);
    rst = r;
    a   = va;
    b   = vb;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [W-1:0] es,
                       input logic ec);
    n_cmp++;
    if (sum !== es || carry !== ec) begin
      n_bad++;
      $display("FAIL %s: got sum=%0d carry=%0b, want sum=%0d carry=%0b",
               nm, sum, carry, es, ec);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    a = '0;
    b = '0;
    hx = 1'b0; hy = 1'b0;
    fx = 1'b0; fy = 1'b0; fz = 1'b0;

    vt[0]  = '{"rst0",     1'b1, 16'd5,     16'd5,     16'd0,     1'b0};
    vt[1]  = '{"rst1",     1'b1, 16'd5,     16'd5,     16'd0,     1'b0};
    vt[2]  = '{"first",    1'b0, 16'd5,     16'd5,     16'd10,    1'b0};
    vt[3]  = '{"1+0",      1'b0, 16'd1,     16'd0,     16'd1,     1'b0};
    vt[4]  = '{"256+44",   1'b0, 16'd256,   16'd44,    16'd300,   1'b0};
    vt[5]  = '{"fe+1",     1'b0, 16'd65534, 16'd1,     16'd65535, 1'b0};
    vt[6]  = '{"fe+2",     1'b0, 16'd65534, 16'd2,     16'd0,     1'b1};
    vt[7]  = '{"fe+3",     1'b0, 16'd65534, 16'd3,     16'd1,     1'b1};
    vt[8]  = '{"max+max",  1'b0, 16'd65535, 16'd65535, 16'd65534, 1'b1};
    vt[9]  = '{"rst_mid",  1'b1, 16'd65535, 16'd65535, 16'd0,     1'b0};
    vt[10] = '{"aaaa5555", 1'b0, 16'hAAAA,  16'h5555,  16'hFFFF,  1'b0};
    vt[11] = '{"msb+msb",  1'b0, 16'h8000,  16'h8000,  16'h0000,  1'b1};
    vt[12] = '{"1234",     1'b0, 16'h1234,  16'h4321,  16'h5555,  1'b0};
    vt[13] = '{"ripple",   1'b0, 16'h7FFF,  16'h0001,  16'h8000,  1'b0};

    // Cell truth tables (combinational).
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_sc;
      hx = i[1];
      hy = i[0];
      #1;
      case (i)
        0:       exp_sc = 2'b00;
        1, 2:    exp_sc = 2'b10;
        default: exp_sc = 2'b01;
      endcase
      n_cmp++;
      if ({hs, hc} !== exp_sc) begin
        n_bad++;
        $display("FAIL ha%0d: got sc=%b want sc=%b", i, {hs, hc}, exp_sc);
      end
    end
    for (int i = 0; i < 8; i++) begin
      int ones;
      fx = i[2];
      fy = i[1];
      fz = i[0];
      #1;
      ones = int'(i[2]) + int'(i[1]) + int'(i[0]);
      n_cmp++;
      if (fs !== ones[0] || fc !== (ones >= 2)) begin
        n_bad++;
        $display("FAIL fa%0d: got s=%b c=%b want s=%b c=%b",
                 i, fs, fc, ones[0], (ones >= 2));
      end
    end

    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      step(vt[i].rst, vt[i].a, vt[i].b);
      check(vt[i].name, vt[i].sum, vt[i].carry);
    end

    // Outputs hold between edges even when inputs move.
    a = 16'd9;
    b = 16'd9;
    #3;
    check("hold", 16'h8000, 1'b0);

    // Mid-stream reset discards the in-flight pair.
    step(1'b0, 16'd100, 16'd200);
    check("pre_rst", 16'd300, 1'b0);
    step(1'b1, 16'd7, 16'd8);
    check("discard", 16'd0, 1'b0);
    step(1'b0, 16'd3, 16'd4);
    check("resume", 16'd7, 1'b0);

    // Random pairs against a 17-bit reference sum.
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [W:0]   ref_v;
      ra = W'($urandom);
      rb = W'($urandom);
      ref_v = {1'b0, ra} + {1'b0, rb};
      step(1'b0, ra, rb);
      n_cmp++;
      if ({carry, sum} !== ref_v) begin
        n_bad++;
        $display("FAIL rnd%0d: a=%0d b=%0d got %0d want %0d",
                 i, ra, rb, {carry, sum}, ref_v);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
